conv3x3_stream: RTL

CONV3X3_STREAM -- requirements
Module: conv3x3_stream

---
 rtl/conv3x3_pkg.sv | 23 ++
 rtl/conv3x3_linebuf.sv | 40 ++++
 rtl/conv3x3_stream.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/conv3x3_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conv3x3_pkg
// Description : Shared constants and helpers for the 3x3 streaming filter.
//               Optional feature macro: CONV3X3_SOBEL_EN (enables mode 3).
// Revision    : 1.0 - initial release
// ============================================================================
package conv3x3_pkg;

    // Kernel select encodings carried on the mode port
    localparam logic [1:0] MODE_PASS  = 2'd0;
    localparam logic [1:0] MODE_GAUSS = 2'd1;
    localparam logic [1:0] MODE_SHARP = 2'd2;
    localparam logic [1:0] MODE_SOBEL = 2'd3;

    // Kernel accumulators need four guard bits above the pixel width:
    // the gaussian weight sum is 16 and sharpen/sobel stay inside +/-2^(DATA_W+3).
    function automatic int acc_width(input int data_w);
        return data_w + 4;
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv3x3_linebuf.sv
`default_nettype none
// ============================================================================
// Module      : conv3x3_linebuf
// Description : Two-row line buffer. Row 1 holds line y-1, row 2 holds line
//               y-2. A write at column c moves row1[c] into row2[c] and stores
//               the new pixel in row1[c]; reads are combinational at the same
//               column so the current column of the window is available in
//               the accepting cycle.
//               Optional feature macro: CONV3X3_SOBEL_EN (not used here).
// Revision    : 1.0 - initial release
// ============================================================================
module conv3x3_linebuf #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 320,
    parameter int COL_W  = $clog2(IMG_W)
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [COL_W-1:0]  i_col,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic [DATA_W-1:0] o_row1,
    output logic [DATA_W-1:0] o_row2
);

    logic [DATA_W-1:0] r_row1 [IMG_W];
    logic [DATA_W-1:0] r_row2 [IMG_W];

    assign o_row1 = r_row1[i_col];
    assign o_row2 = r_row2[i_col];

    // Shift the column down one line on every accepted pixel (contents not reset)
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_row1[i_col] <= i_wr_data;
            r_row2[i_col] <= r_row1[i_col];
        end
    end

endmodule
`default_nettype wire

// File: rtl/conv3x3_stream.sv
`default_nettype none
// ============================================================================
// Module      : conv3x3_stream
// Description : Streaming 3x3 image filter (pass / gaussian / sharpen /
//               sobel) over raster-order pixels. Produces only interior
//               centres, two cycles after the pixel completing the window.
//               Optional feature macro: CONV3X3_SOBEL_EN - when undefined,
//               mode 3 falls back to pass-through and no sobel logic exists.
// Revision    : 1.0 - initial release
// ============================================================================
module conv3x3_stream
    import conv3x3_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 320,
    parameter int IMG_H  = 240
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic              in_valid,
    input  logic              in_sof,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sof,
    output logic              out_eol,
    output logic              out_eof
);

    localparam int c_acc_w = acc_width(DATA_W);
    localparam int c_col_w = $clog2(IMG_W);
    localparam int c_row_w = $clog2(IMG_H + 1);

    localparam logic [c_col_w-1:0]  c_x_last  = c_col_w'(IMG_W - 1);
    localparam logic [c_col_w-1:0]  c_x_first = c_col_w'(2);
    localparam logic [c_row_w-1:0]  c_y_first = c_row_w'(2);
    localparam logic [c_row_w-1:0]  c_y_last  = c_row_w'(IMG_H - 1);
    localparam logic [c_row_w-1:0]  c_y_end   = c_row_w'(IMG_H);
    localparam logic [DATA_W-1:0]   c_pix_max = '1;
    localparam logic [c_acc_w-1:0]  c_round   = c_acc_w'(8);

    // ---------------------------------------------------------------- input
    logic [c_col_w-1:0] r_x;
    logic [c_row_w-1:0] r_y;
    logic               r_armed;
    logic [1:0]         r_mode;

    logic               w_take;
    logic               w_fire;
    logic               w_wrap;
    logic [c_col_w-1:0] w_px;
    logic [c_row_w-1:0] w_py;

    // A pixel counts when it starts a frame, or when a frame is open and
    // not yet complete; enable low masks in_valid entirely.
    assign w_take = enable && in_valid && (in_sof || (r_armed && (r_y < c_y_end)));
    assign w_px   = in_sof ? '0 : r_x;
    assign w_py   = in_sof ? '0 : r_y;
    assign w_wrap = (w_px == c_x_last);
    assign w_fire = w_take && (w_px >= c_x_first) && (w_py >= c_y_first);

    // Raster position, frame-armed flag and per-frame mode capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x     <= '0;
            r_y     <= '0;
            r_armed <= 1'b0;
            r_mode  <= MODE_PASS;
        end else if (w_take) begin
            r_x <= w_wrap ? '0 : w_px + 1'b1;
            r_y <= w_wrap ? w_py + 1'b1 : w_py;
            if (in_sof) begin
                r_armed <= 1'b1;
                r_mode  <= mode;
            end
        end
    end

    // --------------------------------------------------------------- window
    logic [DATA_W-1:0]           w_row1;
    logic [DATA_W-1:0]           w_row2;
    logic [2:0][DATA_W-1:0]      w_col_now;
    logic [2:0][DATA_W-1:0]      r_col_d1;
    logic [2:0][DATA_W-1:0]      r_col_d2;

    conv3x3_linebuf #(
        .DATA_W (DATA_W),
        .IMG_W  (IMG_W),
        .COL_W  (c_col_w)
    ) u_linebuf (
        .clk       (clk),
        .i_wr_en   (w_take),
        .i_col     (w_px),
        .i_wr_data (in_data),
        .o_row1    (w_row1),
        .o_row2    (w_row2)
    );

    // Index 0 = line y-2 (top), 1 = line y-1, 2 = line y (bottom)
    assign w_col_now = {in_data, w_row1, w_row2};

    // Keep the two previously accepted columns (x-1, x-2)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col_d1 <= '0;
            r_col_d2 <= '0;
        end else if (w_take) begin
            r_col_d1 <= w_col_now;
            r_col_d2 <= r_col_d1;
        end
    end

    function automatic logic [c_acc_w-1:0] ext(input logic [DATA_W-1:0] v);
        return {{(c_acc_w - DATA_W){1'b0}}, v};
    endfunction

    logic [c_acc_w-1:0] w_tl, w_tm, w_tr, w_ml, w_mm, w_mr, w_bl, w_bm, w_br;
    assign w_tl = ext(r_col_d2[0]);
    assign w_tm = ext(r_col_d1[0]);
    assign w_tr = ext(w_col_now[0]);
    assign w_ml = ext(r_col_d2[1]);
    assign w_mm = ext(r_col_d1[1]);
    assign w_mr = ext(w_col_now[1]);
    assign w_bl = ext(r_col_d2[2]);
    assign w_bm = ext(r_col_d1[2]);
    assign w_br = ext(w_col_now[2]);

    // -------------------------------------------------------- kernel sums
    logic [c_acc_w-1:0] w_gauss;
    logic [c_acc_w-1:0] w_sharp;
    logic [c_acc_w-1:0] w_sum;
    logic [1:0]         w_kmode;

    assign w_gauss = w_tl + (w_tm << 1) + w_tr
                   + (w_ml << 1) + (w_mm << 2) + (w_mr << 1)
                   + w_bl + (w_bm << 1) + w_br;

    // Two's complement in c_acc_w bits; the true range always fits
    assign w_sharp = (w_mm << 2) + w_mm - w_tm - w_bm - w_ml - w_mr;

`ifdef CONV3X3_SOBEL_EN
    function automatic logic [c_acc_w-1:0] abs_acc(input logic [c_acc_w-1:0] v);
        return v[c_acc_w-1] ? (~v + 1'b1) : v;
    endfunction

    logic [c_acc_w-1:0] w_gx;
    logic [c_acc_w-1:0] w_gy;
    logic [c_acc_w-1:0] w_sobel;

    assign w_gx    = (w_tr + (w_mr << 1) + w_br) - (w_tl + (w_ml << 1) + w_bl);
    assign w_gy    = (w_bl + (w_bm << 1) + w_br) - (w_tl + (w_tm << 1) + w_tr);
    assign w_sobel = abs_acc(w_gx) + abs_acc(w_gy);
    assign w_kmode = r_mode;
`else
    assign w_kmode = (r_mode == MODE_SOBEL) ? MODE_PASS : r_mode;
`endif

    // Select the raw kernel result for the active frame mode
    always_comb begin
        w_sum = w_mm;
        case (w_kmode)
            MODE_GAUSS: w_sum = w_gauss;
            MODE_SHARP: w_sum = w_sharp;
`ifdef CONV3X3_SOBEL_EN
            MODE_SOBEL: w_sum = w_sobel;
`endif
            default:    w_sum = w_mm;
        endcase
    end

    // ------------------------------------------------------------ stage 1
    logic               r_s1_valid;
    logic [c_acc_w-1:0] r_s1_sum;
    logic [1:0]         r_s1_mode;
    logic               r_s1_sof;
    logic               r_s1_eol;
    logic               r_s1_eof;

    // Register the kernel sum with its mode and frame-position flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_sum   <= '0;
            r_s1_mode  <= MODE_PASS;
            r_s1_sof   <= 1'b0;
            r_s1_eol   <= 1'b0;
            r_s1_eof   <= 1'b0;
        end else begin
            r_s1_valid <= w_fire;
            r_s1_sof   <= w_fire && (w_px == c_x_first) && (w_py == c_y_first);
            r_s1_eol   <= w_fire && w_wrap;
            r_s1_eof   <= w_fire && w_wrap && (w_py == c_y_last);
            if (w_fire) begin
                r_s1_sum  <= w_sum;
                r_s1_mode <= w_kmode;
            end
        end
    end

    // ------------------------------------------------------------ stage 2
    logic [DATA_W-1:0] w_gauss_norm;
    logic [DATA_W-1:0] w_norm;

    assign w_gauss_norm = DATA_W'((r_s1_sum + c_round) >> 4);

    // Normalise or clamp the stage-1 sum into pixel range
    always_comb begin
        w_norm = r_s1_sum[DATA_W-1:0];
        case (r_s1_mode)
            MODE_GAUSS: w_norm = w_gauss_norm;
            MODE_SHARP: begin
                if (r_s1_sum[c_acc_w-1]) begin
                    w_norm = '0;
                end else if (|r_s1_sum[c_acc_w-2:DATA_W]) begin
                    w_norm = c_pix_max;
                end
            end
`ifdef CONV3X3_SOBEL_EN
            MODE_SOBEL: begin
                if (|r_s1_sum[c_acc_w-1:DATA_W]) begin
                    w_norm = c_pix_max;
                end
            end
`endif
            default: ;
        endcase
    end

    // Output register: data and flags aligned with out_valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
            out_eof   <= 1'b0;
        end else begin
            out_valid <= r_s1_valid;
            out_sof   <= r_s1_sof;
            out_eol   <= r_s1_eol;
            out_eof   <= r_s1_eof;
            if (r_s1_valid) begin
                out_data <= w_norm;
            end
        end
    end

endmodule
`default_nettype wire
